// File: rtl/partial_sum_accumulator.sv
// Accumulates a stream of unsigned partial products per output node, then
// requantizes the sum with a right shift and holds it until downstream takes it.
module partial_sum_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pp_valid,
  output logic             pp_ready,
  input  logic [IN_W-1:0]  partial_product,
  input  logic             pp_last,
  input  logic [3:0]       shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic {
    ACC   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             sat_p0;

  logic             take;
  logic [ACC_W:0]   add_res;
  logic [CNT_W-1:0] cnt_nx;
  logic             sat_nx;
  logic [OUT_W:0]   rq_res;

  // MSB of the result flags that the sum clipped at full scale.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [IN_W-1:0]  b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, b};
    if (s[ACC_W]) begin
      s = {1'b1, {ACC_W{1'b1}}};
    end
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    r = c;
    if (c != {CNT_W{1'b1}}) begin
      r = c + 1'b1;
    end
    return r;
  endfunction

  // MSB of the result flags that the shifted value did not fit in OUT_W bits.
  function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0] a,
                                             input logic [3:0]       sh);
    logic [ACC_W-1:0] shifted;
    logic [OUT_W:0]   r;
    shifted = a >> sh;
    if (|shifted[ACC_W-1:OUT_W]) begin
      r = {1'b1, {OUT_W{1'b1}}};
    end else begin
      r = {1'b0, shifted[OUT_W-1:0]};
    end
    return r;
  endfunction

  assign take    = pp_valid && pp_ready;
  assign add_res = sat_add(acc_p0, partial_product);
  assign cnt_nx  = sat_inc(cnt_p0);
  assign sat_nx  = sat_p0 | add_res[ACC_W];
  assign rq_res  = requant(add_res[ACC_W-1:0], shift);

  always_comb begin
    state_nx  = state;
    pp_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        pp_ready = !rst;
        if (pp_valid && !rst && pp_last) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = ACC;
        end
      end
      default: state_nx = ACC;
    endcase
  end

  // Stage p0: running node sum; the result registers capture it on the last beat.
  // The running sum is cleared as soon as the result is captured, so the node
  // following a drain always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc_p0    <= '0;
      cnt_p0    <= '0;
      sat_p0    <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        if (pp_last) begin
          acc_p0    <= '0;
          cnt_p0    <= '0;
          sat_p0    <= 1'b0;
          out_data  <= rq_res[OUT_W-1:0];
          out_count <= cnt_nx;
          out_sat   <= sat_nx | rq_res[OUT_W];
        end else begin
          acc_p0 <= add_res[ACC_W-1:0];
          cnt_p0 <= cnt_nx;
          sat_p0 <= sat_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Scoreboard bench: each driven node pushes its expected result, and the
// output monitor pops and compares on every completed output handshake.
module tb_partial_sum_accumulator;

  localparam int IN_W  = 16;
  localparam int ACC_W = 24;
  localparam int OUT_W = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pp_valid = 1'b0;
  logic             pp_ready;
  logic [IN_W-1:0]  partial_product = '0;
  logic             pp_last = 1'b0;
  logic [3:0]       shift = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             sat;
  } result_t;

  result_t sb[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc = 0;
  int      last_accept_cyc = 0;

  longint  m_acc = 0;
  int      m_cnt = 0;
  bit      m_sat = 0;

  partial_sum_accumulator #(
    .IN_W (IN_W),
    .ACC_W(ACC_W),
    .OUT_W(OUT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pp_valid       (pp_valid),
    .pp_ready       (pp_ready),
    .partial_product(partial_product),
    .pp_last        (pp_last),
    .shift          (shift),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_count      (out_count),
    .out_sat        (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      result_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got data=%0d count=%0d sat=%0d, expected no result",
                 out_data, out_count, out_sat);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_count !== e.count || out_sat !== e.sat) begin
          n_errors++;
          $display("FAIL sb_result: got data=%0d count=%0d sat=%0d, expected data=%0d count=%0d sat=%0d",
                   out_data, out_count, out_sat, e.data, e.count, e.sat);
        end
      end
    end
  end

  function automatic void model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 0;
  endfunction

  // Drives one beat (caller is just past a posedge) and returns just past the accepting posedge.
  task automatic send_beat(input int v, input bit last, input int sh);
    bit done;
    done = 0;
    pp_valid        = 1'b1;
    partial_product = IN_W'(v);
    pp_last         = last;
    shift           = 4'(sh);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (pp_ready) begin
        result_t e;
        longint  q;
        done = 1;
        last_accept_cyc = cyc;
        m_acc = m_acc + v;
        if (m_acc > (64'd1 << ACC_W) - 1) begin
          m_acc = (64'd1 << ACC_W) - 1;
          m_sat = 1;
        end
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (last) begin
          q = m_acc >> sh;
          e.sat = m_sat;
          if (q > (1 << OUT_W) - 1) begin
            q = (1 << OUT_W) - 1;
            e.sat = 1;
          end
          e.data  = OUT_W'(q);
          e.count = CNT_W'(m_cnt);
          sb.push_back(e);
          model_reset();
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_timeout: got pp_ready=0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic idle(input int n);
    pp_valid = 1'b0;
    pp_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drained();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    sb.delete();
    model_reset();
    @(negedge clk);
    n_checks++;
    if (pp_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
        out_count !== '0 || out_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b data=%0d cnt=%0d sat=%0b, expected all 0",
               pp_ready, out_valid, out_data, out_count, out_sat);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pp_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got pp_ready=%0b out_valid=%0b, expected 1 and 0",
               pp_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pp_valid = 1'b0;
    out_ready = 1'b1;
    pulse_reset();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_beat(100, 0, 0);
    send_beat(200, 0, 0);
    send_beat(300, 1, 0);
    pp_valid = 1'b0;
    pp_last  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd600 || out_count !== 8'd3 || out_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_latency: got vld=%0b data=%0d cnt=%0d sat=%0b, expected 1 600 3 0",
               out_valid, out_data, out_count, out_sat);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || pp_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_return: got out_valid=%0b pp_ready=%0b, expected 0 and 1",
               out_valid, pp_ready);
    end
    @(posedge clk);
    #1;
    wait_drained();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(100, 0, 0);
    send_beat(200, 0, 0);
    send_beat(300, 1, 0);
    // keep offering a beat that must not be absorbed while the result is pending
    pp_valid        = 1'b1;
    partial_product = 16'd999;
    pp_last         = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd600 || out_count !== 8'd3 || pp_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_cycle%0d: got vld=%0b data=%0d cnt=%0d rdy=%0b, expected 1 600 3 0",
                 i, out_valid, out_data, out_count, pp_ready);
      end
      @(posedge clk);
      #1;
    end
    pp_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (pp_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_release: got pp_ready=%0b out_valid=%0b, expected 1 and 0",
               pp_ready, out_valid);
    end
    @(posedge clk);
    #1;
    wait_drained();
    send_beat(5, 1, 0);
    idle(1);
    wait_drained();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    send_beat(65535, 0, 0);
    send_beat(65535, 1, 0);
    idle(0);
    @(negedge clk);
    n_checks++;
    if (out_data !== 16'hFFFF || out_sat !== 1'b1 || out_count !== 8'd2) begin
      n_errors++;
      $display("FAIL clamp_shift0: got data=%0d sat=%0b cnt=%0d, expected 65535 1 2",
               out_data, out_sat, out_count);
    end
    @(posedge clk);
    #1;
    send_beat(65535, 0, 1);
    send_beat(65535, 1, 1);
    idle(0);
    @(negedge clk);
    n_checks++;
    if (out_data !== 16'hFFFF || out_sat !== 1'b0) begin
      n_errors++;
      $display("FAIL noclamp_shift1: got data=%0d sat=%0b, expected 65535 0", out_data, out_sat);
    end
    @(posedge clk);
    #1;
    // 300 full-scale beats overflow both the 24-bit sum and the 8-bit count
    for (int i = 0; i < 299; i++) send_beat(65535, 0, 15);
    send_beat(65535, 1, 15);
    idle(0);
    @(negedge clk);
    n_checks++;
    if (out_data !== 16'd511 || out_count !== 8'd255 || out_sat !== 1'b1) begin
      n_errors++;
      $display("FAIL acc_sat: got data=%0d cnt=%0d sat=%0b, expected 511 255 1",
               out_data, out_count, out_sat);
    end
    @(posedge clk);
    #1;
    wait_drained();
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    send_beat(42, 1, 2);
    idle(0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd10 || out_count !== 8'd1) begin
      n_errors++;
      $display("FAIL single_beat: got vld=%0b data=%0d cnt=%0d, expected 1 10 1",
               out_valid, out_data, out_count);
    end
    @(posedge clk);
    #1;
    wait_drained();
  endtask

  task automatic test_ignore_last();
    out_ready       = 1'b1;
    pp_valid        = 1'b0;
    pp_last         = 1'b1;
    partial_product = 16'd1234;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || pp_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL ignore_last: got out_valid=%0b pp_ready=%0b, expected 0 and 1",
                 out_valid, pp_ready);
      end
      @(posedge clk);
      #1;
    end
    send_beat(5, 1, 0);
    idle(1);
    wait_drained();
  endtask

  task automatic test_reset_mid_node();
    out_ready = 1'b1;
    send_beat(500, 0, 0);
    send_beat(500, 0, 0);
    idle(1);
    pulse_reset();
    send_beat(7, 1, 0);
    idle(0);
    @(negedge clk);
    n_checks++;
    if (out_data !== 16'd7 || out_count !== 8'd1) begin
      n_errors++;
      $display("FAIL reset_mid_node: got data=%0d cnt=%0d, expected 7 1", out_data, out_count);
    end
    @(posedge clk);
    #1;
    wait_drained();
    // result pending in drain is discarded by reset
    out_ready = 1'b0;
    send_beat(77, 1, 0);
    idle(2);
    pulse_reset();
    out_ready = 1'b1;
    send_beat(9, 1, 0);
    idle(1);
    wait_drained();
  endtask

  task automatic test_back_to_back();
    int c_third;
    out_ready = 1'b1;
    send_beat(100, 0, 0);
    send_beat(200, 0, 0);
    send_beat(300, 1, 0);
    c_third = last_accept_cyc;
    send_beat(42, 1, 0);
    n_checks++;
    if (last_accept_cyc - c_third !== 2) begin
      n_errors++;
      $display("FAIL b2b_gap: got %0d cycles between nodes, expected 2",
               last_accept_cyc - c_third);
    end
    idle(1);
    wait_drained();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_single_beat();
    test_ignore_last();
    test_reset_mid_node();
    test_back_to_back();
    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: got %0d results outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/partial_sum_accumulator.md
PARTIAL_SUM_ACCUMULATOR -- requirements
Module: partial_sum_accumulator

Interface
REQ-001 SHALL have parameter IN_W, default 16, width of incoming partial product.
REQ-002 SHALL have parameter ACC_W, default 24, internal accumulator width (ACC_W > IN_W).
REQ-003 SHALL have parameter OUT_W, default 16, width of requantized output.
REQ-004 SHALL have parameter CNT_W, default 8, width of beat counter.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port pp_valid  input  1  partial product beat valid.
REQ-008 SHALL have port pp_ready  output  1  block accepts a beat.
REQ-009 SHALL have port partial_product  input  IN_W  unsigned product-sum from the vector multiplier.
REQ-010 SHALL have port pp_last  input  1  beat is the final partial product of the current node.
REQ-011 SHALL have port shift  input  4  right-shift amount for requantization, 0..15.
REQ-012 SHALL have port out_valid  output  1  node result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_data  output  OUT_W  requantized node result.
REQ-015 SHALL have port out_count  output  CNT_W  number of beats accumulated for this node.
REQ-016 SHALL have port out_sat  output  1  output or accumulator saturated for this node.

Function
REQ-017 SHALL implement a two-state FSM: ACC (pp_ready=1, out_valid=0) and DRAIN (pp_ready=0, out_valid=1).
REQ-018 Beat transfer SHALL occur only on a cycle with pp_valid=1 and pp_ready=1.
REQ-019 On each ACC transfer: acc <= acc + zero-extended partial_product, saturating at 2^ACC_W-1; sticky acc_sat set on saturation.
REQ-020 On each ACC transfer: count <= count+1, saturating at 2^CNT_W-1.
REQ-021 Transfer with pp_last=1 SHALL move ACC->DRAIN and register out_data, out_count, out_sat from the updated acc/count/acc_sat and shift sampled that cycle.
REQ-022 out_data SHALL be (acc >> shift), clamped to 2^OUT_W-1; out_sat = acc_sat OR clamp occurred.
REQ-023 Latency: out_valid SHALL rise the cycle after the pp_last transfer.
REQ-024 In DRAIN, out_data/out_count/out_sat SHALL hold stable while out_ready=0.
REQ-025 DRAIN with out_ready=1 SHALL return to ACC next cycle with acc, count, acc_sat cleared; out_valid low that cycle.
REQ-026 pp_ready SHALL be 0 throughout DRAIN; no beat is accepted or lost while a result is pending.
REQ-027 pp_last on the first beat of a node SHALL yield out_count=1.
REQ-028 pp_valid=0 SHALL leave all state unchanged; pp_last without pp_valid SHALL be ignored.
REQ-029 Partial-product inputs are unsigned; no sign extension anywhere.

Reset
REQ-030 rst=1 SHALL asynchronously force state ACC, acc=0, count=0, acc_sat=0.
REQ-031 During and after reset: out_valid=0, out_data=0, out_count=0, out_sat=0; pp_ready=0 while rst=1 and 1 the first cycle after release.
REQ-032 Reset mid-node or mid-DRAIN SHALL discard the partial node; the next beat after release starts a new node.

Verification
REQ-033 Beats 100, 200, 300 (last on third), shift=0 -> out_valid next cycle, out_data=600, out_count=3, out_sat=0.
REQ-034 Same node with out_ready held 0 for 5 cycles -> out_data=600 stable, pp_ready=0 for all 5 cycles, accepted on cycle 6, pp_ready=1 the following cycle.
REQ-035 Beats 65535, 65535 (last), shift=0 -> out_data=65535, out_sat=1; repeat with shift=1 -> out_data=65535, out_sat=0.
REQ-036 Single beat 42 with pp_last, shift=2 -> out_data=10, out_count=1.
REQ-037 Two beats of 500 then rst pulse, then beat 7 with last, shift=0 -> out_data=7, out_count=1.
REQ-038 Two nodes back-to-back with out_ready=1 and pp_valid=1 continuously -> exactly one dead cycle per node boundary, results 600 then 42, no beat dropped or duplicated.
